// File: rtl/rr_arbiter_pkg.sv
// Shared definitions for the rr_arbiter block: mode encodings, default
// sizing constants and the arbiter state type.
package rr_arbiter_pkg;

    localparam logic ARB_MODE_RR    = 1'b0;
    localparam logic ARB_MODE_FIXED = 1'b1;

    localparam int ARB_N_DEFAULT        = 4;
    localparam int ARB_MAX_HOLD_DEFAULT = 8;
    localparam int ARB_HOLD_W           = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_prio_pick.sv
// Combinational rotating-priority picker: returns the first unmasked request
// found searching upward from start_i, wrapping from N-1 back to 0.
module arb_prio_pick #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   req_i,
    input  logic [IDW-1:0] start_i,
    input  logic [N-1:0]   mask_i,
    output logic [N-1:0]   onehot_o,
    output logic [IDW-1:0] idx_o,
    output logic           any_o
);

    logic [N-1:0] eligible;
    int           pos;

    assign eligible = req_i & ~mask_i;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; otherwise synthesis infers a latch.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        any_o    = 1'b0;
        pos      = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(start_i) + i;
            if (pos >= N) pos = pos - N;
            if (!any_o && eligible[pos]) begin
                any_o         = 1'b1;
                onehot_o[pos] = 1'b1;
                idx_o         = IDW'(pos);
            end
        end
    end

endmodule

// File: rtl/rr_arbiter.sv
// N-requester arbiter with registered one-hot grant, runtime round-robin or
// fixed-priority policy. Define ARB_HOLD_LIMIT_EN to compile in the hold limit.
module rr_arbiter
    import rr_arbiter_pkg::*;
#(
    parameter int N        = ARB_N_DEFAULT,
    parameter int IDW      = $clog2(N),
    parameter int MAX_HOLD = ARB_MAX_HOLD_DEFAULT
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           mode,
    output logic [N-1:0]   gnt,
    output logic           gnt_valid,
    output logic [IDW-1:0] gnt_id
);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("rr_arbiter: N must be in 2..16");
    end
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
        $error("rr_arbiter: MAX_HOLD must be in 1..255");
    end

    arb_state_e     state_q, state_d;
    logic [N-1:0]   gnt_q, gnt_d;
    logic           valid_q, valid_d;
    logic [IDW-1:0] id_q, id_d;
    logic [IDW-1:0] last_q, last_d;

    logic [IDW-1:0] start_idx;
    logic [N-1:0]   pick_mask;
    logic [N-1:0]   pick_onehot;
    logic [IDW-1:0] pick_idx;
    logic           pick_any;
    logic           owner_req;
    logic           preempt;
    logic           arb_en;

    assign owner_req = |(req & gnt_q);

`ifdef ARB_HOLD_LIMIT_EN
    logic [ARB_HOLD_W-1:0] hold_q, hold_d;
    logic                  others_req;

    // hold_q counts edges the grant has been kept, so MAX_HOLD-1 means the
    // owner has just completed its MAX_HOLD-th grant cycle.
    assign others_req = |(req & ~gnt_q);
    assign preempt    = (state_q == ST_OWNED) && owner_req && others_req &&
                        (hold_q >= ARB_HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        hold_d = hold_q;
        if (arb_en) begin
            hold_d = '0;
        end else if (state_q == ST_OWNED && hold_q != ARB_HOLD_W'(MAX_HOLD)) begin
            hold_d = hold_q + ARB_HOLD_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) hold_q <= '0;
        else        hold_q <= hold_d;
    end
`else
    assign preempt = 1'b0;
`endif

    // Fixed priority always searches from 0; round-robin starts after last.
    assign start_idx = (mode == ARB_MODE_FIXED) ? '0 :
                       (last_q == IDW'(N - 1))  ? '0 : last_q + IDW'(1);
    assign pick_mask = preempt ? gnt_q : '0;
    assign arb_en    = (state_q == ST_IDLE) ? |req : (!owner_req || preempt);

    arb_prio_pick #(
        .N   (N),
        .IDW (IDW)
    ) u_pick (
        .req_i    (req),
        .start_i  (start_idx),
        .mask_i   (pick_mask),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        id_d    = id_q;
        last_d  = last_q;
        if (arb_en) begin
            if (pick_any) begin
                state_d = ST_OWNED;
                gnt_d   = pick_onehot;
                id_d    = pick_idx;
                last_d  = pick_idx;
            end else begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        end
        valid_d = |gnt_d;
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            valid_q <= 1'b0;
            id_q    <= '0;
            last_q  <= IDW'(N - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            id_q    <= id_d;
            last_q  <= last_d;
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = valid_q;
    assign gnt_id    = id_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N=4, MAX_HOLD=4): directed scenarios
// plus sticky random requests, compared against a behavioural owner model.
module tb_rr_arbiter;
    import rr_arbiter_pkg::*;

    localparam int N        = 4;
    localparam int IDW      = 2;
    localparam int MAX_HOLD = 4;

    logic           clock = 1'b0;
    logic           reset;
    logic [N-1:0]   req;
    logic           mode;
    logic [N-1:0]   gnt;
    logic           gnt_valid;
    logic [IDW-1:0] gnt_id;

    int total = 0;
    int bad   = 0;

    // Reference model: current owner index (-1 = none), last winner,
    // reported id and how many grant cycles the owner has had so far.
    int m_owner;
    int m_last;
    int m_id;
    int m_held;

    always #5 clock = ~clock;

    rr_arbiter #(
        .N        (N),
        .IDW      (IDW),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .mode      (mode),
        .gnt       (gnt),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input logic m, input int last);
        for (int i = 1; i <= N; i++) begin
            int j;
            j = (m == ARB_MODE_FIXED) ? i - 1 : (last + i) % N;
            if (r[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_id    = 0;
        m_held  = 0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic m);
        logic [N-1:0] avail;
        bit           preempt;
        int           w;
        avail = r;
        if (m_owner >= 0 && r[m_owner]) begin
            preempt = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
            if (m_held >= MAX_HOLD && (r & ~(4'b0001 << m_owner)) != 0) preempt = 1'b1;
`endif
            if (!preempt) begin
                m_held++;
                return;
            end
            avail[m_owner] = 1'b0;
        end else if (m_owner < 0 && r == 0) begin
            return;
        end
        w = pick(avail, m, m_last);
        if (w >= 0) begin
            m_owner = w;
            m_last  = w;
            m_id    = w;
            m_held  = 1;
        end else begin
            m_owner = -1;
        end
    endtask

    function automatic logic [N-1:0] exp_gnt();
        return (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    endfunction

    task automatic step(input string tag);
        @(posedge clock);
        model_edge(req, mode);
        #1;
        check({tag, ".gnt"}, gnt, exp_gnt());
        check({tag, ".valid"}, gnt_valid, m_owner >= 0);
        check({tag, ".id"}, gnt_id, m_id);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        req   = '0;
        #1;
        model_reset();
        #1;
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        req   = '0;
        mode  = ARB_MODE_RR;
        model_reset();
        #12;
        check("por.gnt", gnt, 0);
        check("por.valid", gnt_valid, 0);
        check("por.id", gnt_id, 0);
        reset = 1'b1;

        // Asynchronous reset in the middle of a grant
        req = 4'b0100;
        step("rst_pre");
        check("rst_pre.owner", gnt, 4'b0100);
        #1;
        reset = 1'b0;
        #1;
        check("rst_async.gnt", gnt, 0);
        check("rst_async.valid", gnt_valid, 0);
        check("rst_async.id", gnt_id, 0);
        model_reset();
        #2;
        reset = 1'b1;
        req   = 4'b0001;
        step("rst_post");
        check("rst_post.first", gnt, 4'b0001);

        // Round-robin rotation with each owner dropping for one cycle
        do_reset();
        mode = ARB_MODE_RR;
        req  = 4'b1111;
        step("rr");
        check("rr.first", gnt_id, 0);
        for (int k = 1; k <= 4; k++) begin
            req = 4'b1111 & ~(4'b0001 << ((k - 1) % 4));
            step("rr");
            check("rr.seq", gnt_id, k % 4);
            check("rr.no_idle", gnt_valid, 1);
        end

        // Fixed priority; a higher-priority arrival does not preempt
        do_reset();
        mode = ARB_MODE_FIXED;
        req  = 4'b1010;
        step("fp");
        check("fp.first", gnt, 4'b0010);
        req = 4'b1000;
        step("fp");
        check("fp.handover", gnt, 4'b1000);
        req = 4'b1001;
        repeat (2) begin
            step("fp");
            check("fp.no_preempt", gnt, 4'b1000);
        end

        // Hold limit: requester 2 keeps requesting while 0 waits
        do_reset();
        mode = ARB_MODE_RR;
        req  = 4'b0100;
        step("hold");
        check("hold.first", gnt, 4'b0100);
        req = 4'b0101;
        repeat (3) begin
            step("hold");
            check("hold.kept", gnt, 4'b0100);
        end
`ifdef ARB_HOLD_LIMIT_EN
        step("hold");
        check("hold.forced", gnt, 4'b0001);
`else
        repeat (20) begin
            step("hold");
            check("hold.kept_long", gnt, 4'b0100);
        end
`endif

        // Simultaneous release and new request, then release to idle
        do_reset();
        mode = ARB_MODE_RR;
        req  = 4'b0010;
        step("sim");
        req = 4'b1000;
        step("sim");
        check("sim.regrant", gnt, 4'b1000);
        req = 4'b0000;
        step("sim");
        check("sim.idle_gnt", gnt, 0);
        check("sim.idle_valid", gnt_valid, 0);

        // Sticky random requests with occasional policy switches
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++) begin
                if ($urandom_range(0, 3) == 0) req[b] = ~req[b];
            end
            if ($urandom_range(0, 31) == 0) mode = ~mode;
            step("rand");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
